// File: rtl/udp_pkt_arbiter.sv
// udp_pkt_arbiter
//   Merges two first-word-fall-through requester FIFOs carrying framed
//   packets (bit9 = SOF, bit8 = EOF, bits 7:0 = payload) into a single
//   destination FIFO. Whole packets are granted with round-robin priority.
//   Words that arrive outside a packet (no SOF) are dropped. Packets that
//   reach MAX_PKT_WORDS words without an EOF are force-terminated.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   req0_empty/req0_dout  : requester 0 FIFO status and head word
//   req0_re               : requester 0 pop strobe (combinational)
//   req1_empty/req1_dout  : requester 1 FIFO status and head word
//   req1_re               : requester 1 pop strobe (combinational)
//   dst_full              : destination FIFO full
//   dst_we/dst_din        : destination write strobe and word (combinational)
//   grant                 : registered one-hot owner, 00 when idle
//   busy                  : registered, high while a packet is being moved
//   pkt_cnt0/pkt_cnt1     : packets completed per requester (wrapping)
//   drop_cnt              : orphan words discarded (wrapping)
//   trunc_cnt             : packets force-terminated (wrapping)
module udp_pkt_arbiter #(
   parameter int CNT_WIDTH     = 16,
   parameter int MAX_PKT_WORDS = 1500
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0_empty,
   input  logic [9:0]           req0_dout,
   output logic                 req0_re,
   input  logic                 req1_empty,
   input  logic [9:0]           req1_dout,
   output logic                 req1_re,
   input  logic                 dst_full,
   output logic                 dst_we,
   output logic [9:0]           dst_din,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pkt_cnt0,
   output logic [CNT_WIDTH-1:0] pkt_cnt1,
   output logic [CNT_WIDTH-1:0] drop_cnt,
   output logic [CNT_WIDTH-1:0] trunc_cnt
);

   localparam int WC_W = $clog2(MAX_PKT_WORDS + 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state, state_nx;
   logic            last, last_nx;
   logic [1:0]      grant_nx;
   logic [WC_W-1:0] wcnt, wcnt_nx;

   logic [1:0]       empty;
   logic [1:0][9:0]  head;
   logic [1:0]       req_re;
   logic             pref, cand, own, final_word;
   logic [1:0]       inc_pkt;
   logic             inc_drop, inc_trunc;

   assign empty   = {req1_empty, req0_empty};
   assign head    = {req1_dout, req0_dout};
   assign req0_re = req_re[0];
   assign req1_re = req_re[1];

   // Requester that did not win last goes first; the other one only
   // gets a look when the preferred FIFO is empty.
   assign pref = ~last;
   assign cand = empty[pref] ? ~pref : pref;
   assign own  = grant[1];
   // wcnt counts words already moved, so this word is number wcnt+1
   assign final_word = (wcnt == WC_W'(MAX_PKT_WORDS - 1));

   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      last_nx   = last;
      wcnt_nx   = wcnt;
      req_re    = '0;
      dst_we    = 1'b0;
      dst_din   = '0;
      inc_pkt   = '0;
      inc_drop  = 1'b0;
      inc_trunc = 1'b0;
      case (state)
         IDLE: begin
            if (!empty[cand]) begin
               if (head[cand][9]) begin
                  // SOF at the head: grant now, move words next cycle
                  grant_nx = cand ? 2'b10 : 2'b01;
                  wcnt_nx  = '0;
                  state_nx = XFER;
               end else begin
                  // orphan word: pop and discard, priority unchanged
                  req_re[cand] = 1'b1;
                  inc_drop     = 1'b1;
               end
            end
         end
         XFER: begin
            if (!empty[own] && !dst_full) begin
               req_re[own] = 1'b1;
               dst_we      = 1'b1;
               dst_din     = head[own];
               wcnt_nx     = wcnt + WC_W'(1);
               if (head[own][8] || final_word) begin
                  dst_din[8]   = 1'b1;
                  inc_pkt[own] = 1'b1;
                  inc_trunc    = ~head[own][8];
                  last_nx      = own;
                  grant_nx     = '0;
                  state_nx     = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      // no strobes may leave the block while reset is held
      if (reset) begin
         req_re = '0;
         dst_we = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         last  <= 1'b1;
         wcnt  <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         busy  <= (state_nx == XFER);
         last  <= last_nx;
         wcnt  <= wcnt_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pkt_cnt0  <= '0;
         pkt_cnt1  <= '0;
         drop_cnt  <= '0;
         trunc_cnt <= '0;
      end else begin
         if (inc_pkt[0]) pkt_cnt0  <= pkt_cnt0  + CNT_WIDTH'(1);
         if (inc_pkt[1]) pkt_cnt1  <= pkt_cnt1  + CNT_WIDTH'(1);
         if (inc_drop)   drop_cnt  <= drop_cnt  + CNT_WIDTH'(1);
         if (inc_trunc)  trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_udp_pkt_arbiter.sv
// Testbench for udp_pkt_arbiter: FWFT source FIFOs modelled as queues,
// destination writes captured to a queue, table-driven vectors, directed
// multi-cycle sequences and randomized traffic against a packet-level model.
module tb_udp_pkt_arbiter;
   localparam int CW   = 4;
   localparam int MAXW = 4;
   localparam int BUDGET = 3000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0_empty, req1_empty, req0_re, req1_re;
   logic [9:0]    req0_dout, req1_dout, dst_din;
   logic          dst_full = 1'b0;
   logic          dst_we, busy;
   logic [1:0]    grant;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1, drop_cnt, trunc_cnt;

   udp_pkt_arbiter #(.CNT_WIDTH(CW), .MAX_PKT_WORDS(MAXW)) dut (
      .clock(clock), .reset(reset),
      .req0_empty(req0_empty), .req0_dout(req0_dout), .req0_re(req0_re),
      .req1_empty(req1_empty), .req1_dout(req1_dout), .req1_re(req1_re),
      .dst_full(dst_full), .dst_we(dst_we), .dst_din(dst_din),
      .grant(grant), .busy(busy),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
      .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt));

   always #5 clock = ~clock;

   int n_chk = 0, n_err = 0, viol = 0, cyc = 0, r1_seen = 0;
   logic [9:0] q0[$], q1[$], got[$], mq0[$], mq1[$], mexp[$];
   int we_cyc[$];
   int e_pc0, e_pc1, e_dr, e_tr;

   typedef struct {
      logic [9:0] w0 [8]; int n0;
      logic [9:0] w1 [8]; int n1;
      logic [9:0] ex [8]; int nex;
      int pc0, pc1, dr, tr, gap_at;
   } vec_t;
   vec_t tv [5];

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic drive();
      req0_empty = (q0.size() == 0);
      req0_dout  = req0_empty ? 10'h0 : q0[0];
      req1_empty = (q1.size() == 0);
      req1_dout  = req1_empty ? 10'h0 : q1[0];
   endtask

   // One clock: observe combinational outputs mid-cycle, then apply pops.
   task automatic step();
      logic r0, r1;
      @(negedge clock);
      r0 = req0_re;
      r1 = req1_re;
      if (r1) r1_seen++;
      if (dst_we) begin got.push_back(dst_din); we_cyc.push_back(cyc); end
      if (reset && (r0 || r1 || dst_we)) viol++;
      if (!busy && dst_we) viol++;
      if (busy && ((grant == 2'b01 && r1) || (grant == 2'b10 && r0))) viol++;
      if ((r0 && q0.size() == 0) || (r1 && q1.size() == 0)) viol++;
      @(posedge clock); #1;
      cyc++;
      if (r0 && q0.size() != 0) void'(q0.pop_front());
      if (r1 && q1.size() != 0) void'(q1.pop_front());
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1; dst_full = 1'b0;
      step(); step();
      reset = 1'b0;
      got.delete(); we_cyc.delete();
   endtask

   task automatic run_idle(input bit rnd_full, input string nm);
      int k = 0;
      do begin
         if (rnd_full) dst_full = ($urandom_range(0, 3) == 0);
         step(); k++;
      end while (!(q0.size() == 0 && q1.size() == 0 && !busy) && k < BUDGET);
      dst_full = 1'b0;
      chk({nm, "_drained"}, int'(busy) + q0.size() + q1.size(), 0);
   endtask

   // ---- packet-level reference model -------------------------------------
   function automatic bit m_empty(input int r);
      return (r == 0) ? (mq0.size() == 0) : (mq1.size() == 0);
   endfunction
   function automatic logic [9:0] m_head(input int r);
      return (r == 0) ? mq0[0] : mq1[0];
   endfunction
   task automatic m_pop(input int r);
      if (r == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
   endtask

   // Round robin over whole packets; words outside packets are discarded;
   // the MAXW-th word of an unterminated packet gets its EOF bit forced.
   task automatic run_model();
      int last = 1, r, n;
      logic [9:0] w;
      bit done;
      mq0 = q0; mq1 = q1;
      mexp.delete();
      e_pc0 = 0; e_pc1 = 0; e_dr = 0; e_tr = 0;
      while (!m_empty(0) || !m_empty(1)) begin
         r = m_empty(1 - last) ? last : 1 - last;
         w = m_head(r);
         if (!w[9]) begin
            m_pop(r); e_dr++;
         end else begin
            n = 0; done = 1'b0;
            while (!done && !m_empty(r)) begin
               w = m_head(r); m_pop(r); n++;
               if (!w[8] && n == MAXW) begin w[8] = 1'b1; e_tr++; end
               mexp.push_back(w);
               done = w[8];
            end
            if (done) begin
               if (r == 0) e_pc0++; else e_pc1++;
               last = r;
            end
         end
      end
   endtask

   task automatic cmp_stream(input string nm);
      chk({nm, "_len"}, got.size(), mexp.size());
      for (int i = 0; i < got.size() && i < mexp.size(); i++)
         chk($sformatf("%s_w%0d", nm, i), got[i], mexp[i]);
   endtask

   task automatic cmp_counts(input string nm, input int pc0, input int pc1,
                             input int dr, input int tr);
      chk({nm, "_pkt_cnt0"},  pkt_cnt0,  pc0 % (1 << CW));
      chk({nm, "_pkt_cnt1"},  pkt_cnt1,  pc1 % (1 << CW));
      chk({nm, "_drop_cnt"},  drop_cnt,  dr  % (1 << CW));
      chk({nm, "_trunc_cnt"}, trunc_cnt, tr  % (1 << CW));
      chk({nm, "_grant"},     grant,     0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nseg, len;
      logic [9:0] w;

      // both FIFOs hold a 3-word packet: req0 first, bubble, then req1
      tv[0].w0 = '{10'h201, 10'h002, 10'h103, 0, 0, 0, 0, 0}; tv[0].n0 = 3;
      tv[0].w1 = '{10'h211, 10'h012, 10'h113, 0, 0, 0, 0, 0}; tv[0].n1 = 3;
      tv[0].ex = '{10'h201, 10'h002, 10'h103, 10'h211, 10'h012, 10'h113, 0, 0};
      tv[0].nex = 6; tv[0].pc0 = 1; tv[0].pc1 = 1; tv[0].dr = 0; tv[0].tr = 0; tv[0].gap_at = 3;
      // orphan 0x055 dropped before a proper packet
      tv[1].w0 = '{10'h055, 10'h2AA, 10'h111, 0, 0, 0, 0, 0}; tv[1].n0 = 3;
      tv[1].w1 = '{0, 0, 0, 0, 0, 0, 0, 0}; tv[1].n1 = 0;
      tv[1].ex = '{10'h2AA, 10'h111, 0, 0, 0, 0, 0, 0};
      tv[1].nex = 2; tv[1].pc0 = 1; tv[1].pc1 = 0; tv[1].dr = 1; tv[1].tr = 0; tv[1].gap_at = 0;
      // 6 words without EOF: word 4 closes the packet, 5 and 6 are orphans
      tv[2].w0 = '{10'h201, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 0, 0}; tv[2].n0 = 6;
      tv[2].w1 = '{0, 0, 0, 0, 0, 0, 0, 0}; tv[2].n1 = 0;
      tv[2].ex = '{10'h201, 10'h002, 10'h003, 10'h104, 0, 0, 0, 0};
      tv[2].nex = 4; tv[2].pc0 = 1; tv[2].pc1 = 0; tv[2].dr = 2; tv[2].tr = 1; tv[2].gap_at = 0;
      // single-word packets alternate, SOF inside a packet passes through
      tv[3].w0 = '{10'h3A1, 10'h2B2, 10'h2B3, 10'h1B4, 0, 0, 0, 0}; tv[3].n0 = 4;
      tv[3].w1 = '{10'h3C1, 0, 0, 0, 0, 0, 0, 0}; tv[3].n1 = 1;
      tv[3].ex = '{10'h3A1, 10'h3C1, 10'h2B2, 10'h2B3, 10'h1B4, 0, 0, 0};
      tv[3].nex = 5; tv[3].pc0 = 2; tv[3].pc1 = 1; tv[3].dr = 0; tv[3].tr = 0; tv[3].gap_at = 1;
      // orphan on req1 dropped without disturbing its turn
      tv[4].w0 = '{10'h201, 10'h102, 0, 0, 0, 0, 0, 0}; tv[4].n0 = 2;
      tv[4].w1 = '{10'h0F0, 10'h2F1, 10'h1F2, 0, 0, 0, 0, 0}; tv[4].n1 = 3;
      tv[4].ex = '{10'h201, 10'h102, 10'h2F1, 10'h1F2, 0, 0, 0, 0};
      tv[4].nex = 4; tv[4].pc0 = 1; tv[4].pc1 = 1; tv[4].dr = 1; tv[4].tr = 0; tv[4].gap_at = 0;

      // ---- reset state ----
      drive();
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      cmp_counts("rst", 0, 0, 0, 0);

      // ---- table-driven vectors ----
      for (int t = 0; t < 5; t++) begin
         do_reset();
         for (int i = 0; i < tv[t].n0; i++) q0.push_back(tv[t].w0[i]);
         for (int i = 0; i < tv[t].n1; i++) q1.push_back(tv[t].w1[i]);
         drive();
         run_idle(1'b0, $sformatf("tv%0d", t));
         chk($sformatf("tv%0d_len", t), got.size(), tv[t].nex);
         for (int i = 0; i < got.size() && i < tv[t].nex; i++)
            chk($sformatf("tv%0d_w%0d", t, i), got[i], tv[t].ex[i]);
         cmp_counts($sformatf("tv%0d", t), tv[t].pc0, tv[t].pc1, tv[t].dr, tv[t].tr);
         if (tv[t].gap_at > 0 && we_cyc.size() > tv[t].gap_at)
            chk($sformatf("tv%0d_bubble", t),
                we_cyc[tv[t].gap_at] - we_cyc[tv[t].gap_at - 1], 2);
      end

      // ---- destination stall mid-packet ----
      do_reset();
      q0 = '{10'h201, 10'h002, 10'h003, 10'h104};
      drive();
      k = 0;
      while (got.size() < 2 && k < 20) begin step(); k++; end
      chk("stall_pre_words", got.size(), 2);
      dst_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("stall_grant%0d", i), grant, 2'b01);
         chk($sformatf("stall_nowe%0d", i), got.size(), 2);
      end
      dst_full = 1'b0;
      q0 = '{10'h201, 10'h002, 10'h003, 10'h104};
      run_model();
      q0 = '{10'h003, 10'h104};
      run_idle(1'b0, "stall");
      cmp_stream("stall");
      cmp_counts("stall", 1, 0, 0, 0);

      // ---- reset in the middle of a req1 packet ----
      do_reset();
      q1 = '{10'h211, 10'h012, 10'h013, 10'h014, 10'h115, 10'h221, 10'h122};
      drive();
      k = 0;
      while (got.size() < 2 && k < 20) begin step(); k++; end
      chk("rstmid_pre_words", got.size(), 2);
      do_reset();
      chk("rstmid_busy", busy, 0);
      chk("rstmid_left", q1.size(), 5);
      cmp_counts("rstmid_after_rst", 0, 0, 0, 0);
      run_idle(1'b0, "rstmid");
      chk("rstmid_len", got.size(), 2);
      if (got.size() == 2) begin
         chk("rstmid_w0", got[0], 10'h221);
         chk("rstmid_w1", got[1], 10'h122);
      end
      cmp_counts("rstmid", 0, 1, 3, 0);

      // ---- continuous req0 stream, req1 idle ----
      do_reset();
      r1_seen = 0;
      for (int p = 0; p < 5; p++) begin
         q0.push_back(10'h200 | 10'(p));
         q0.push_back(10'h100 | 10'(p + 8'h40));
      end
      run_model();
      drive();
      run_idle(1'b0, "stream");
      cmp_stream("stream");
      cmp_counts("stream", e_pc0, e_pc1, e_dr, e_tr);
      for (int i = 1; i < we_cyc.size(); i++)
         chk($sformatf("stream_gap%0d", i), we_cyc[i] - we_cyc[i - 1], (i % 2 == 0) ? 2 : 1);
      chk("stream_req1_re", r1_seen, 0);

      // ---- counter wrap: 17 packets and 17 orphans ----
      do_reset();
      for (int i = 0; i < 17; i++) begin
         q0.push_back(10'h300 | 10'($urandom_range(0, 255)));
         q1.push_back(10'($urandom_range(0, 255)));
      end
      run_model();
      drive();
      run_idle(1'b0, "wrap");
      cmp_stream("wrap");
      cmp_counts("wrap", e_pc0, e_pc1, e_dr, e_tr);

      // ---- randomized traffic with random back-pressure ----
      for (int it = 0; it < 8; it++) begin
         do_reset();
         for (int r = 0; r < 2; r++) begin
            nseg = $urandom_range(0, 6);
            for (int s = 0; s < nseg; s++) begin
               if ($urandom_range(0, 3) == 0) begin
                  w = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
                  if (r == 0) q0.push_back(w); else q1.push_back(w);
               end else begin
                  len = $urandom_range(1, 6);
                  for (int j = 0; j < len; j++) begin
                     w = {1'b0, 1'b0, 8'($urandom_range(0, 255))};
                     if (j == 0 || $urandom_range(0, 9) == 0) w[9] = 1'b1;
                     if (j == len - 1 && $urandom_range(0, 3) != 0) w[8] = 1'b1;
                     if (r == 0) q0.push_back(w); else q1.push_back(w);
                  end
               end
            end
            // terminator word: ends any open packet or forms its own
            w = {2'b11, 8'($urandom_range(0, 255))};
            if (r == 0) q0.push_back(w); else q1.push_back(w);
         end
         run_model();
         drive();
         run_idle(1'b1, $sformatf("rnd%0d", it));
         cmp_stream($sformatf("rnd%0d", it));
         cmp_counts($sformatf("rnd%0d", it), e_pc0, e_pc1, e_dr, e_tr);
      end

      chk("protocol_violations", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
